// File: rtl/blink_pkg.sv
// -----------------------------------------------------------------------------
// blink_pkg
// Shared definitions for the status-LED pattern sequencer:
//   - FSM state encoding
//   - default parameter values
//   - tick divider and counter width helpers
//   - normalisation of the loaded length and step fields
// -----------------------------------------------------------------------------
package blink_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_PLAY = 1'b1
    } state_e;

    localparam int unsigned DEF_CLK_HZ  = 25_000_000;
    localparam int unsigned DEF_TICK_HZ = 1000;
    localparam int unsigned DEF_PAT_W   = 16;
    localparam int unsigned DEF_DUR_W   = 12;
    localparam int unsigned DEF_REP_W   = 8;

    // Clock cycles per step tick. The caller guarantees an exact division
    // and a result of at least 2.
    function automatic int unsigned calc_div(input int unsigned clk_hz,
                                             input int unsigned tick_hz);
        return clk_hz / tick_hz;
    endfunction

    // Width of a counter that holds 0..n-1 (never narrower than one bit).
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // A zero or oversized length plays the full pattern register.
    function automatic int unsigned norm_len(input int unsigned len,
                                             input int unsigned pat_w);
        return ((len == 0) || (len > pat_w)) ? pat_w : len;
    endfunction

    // A zero step duration would never end; treat it as one tick.
    function automatic int unsigned norm_step(input int unsigned step);
        return (step == 0) ? 1 : step;
    endfunction

endpackage

// File: rtl/blink_tick.sv
// -----------------------------------------------------------------------------
// blink_tick
// Prescaler producing a one-cycle tick every DIV enabled clock cycles.
// Ports:
//   clk_i   in   system clock
//   arst_i  in   asynchronous active-high reset
//   srst_i  in   synchronous active-high reset
//   clr_i   in   restart the count from 0 (wins over en_i)
//   en_i    in   count enable; the counter holds while low
//   tick_o  out  high for the cycle in which the count is DIV-1 and enabled
// -----------------------------------------------------------------------------
module blink_tick
    import blink_pkg::*;
#(
    parameter int unsigned DIV = 10
) (
    input  logic clk_i,
    input  logic arst_i,
    input  logic srst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic tick_o
);

    localparam int unsigned     PRE_W = cnt_w(DIV);
    localparam logic [PRE_W-1:0] LAST = PRE_W'(DIV - 1);

    logic [PRE_W-1:0] cnt_q;
    logic [PRE_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            // Explicit wrap so a non power-of-two DIV counts 0..DIV-1.
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + PRE_W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            cnt_q <= '0;
        end else if (srst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick_o = en_i && (cnt_q == LAST);

endmodule

// File: rtl/rst_gen.sv
// -----------------------------------------------------------------------------
// rst_gen
// Reset conditioner: asserts its output asynchronously with arst_i and
// releases it synchronously, STAGES clock edges after arst_i drops.
// Ports:
//   clk_i   in   system clock
//   arst_i  in   asynchronous active-high reset request
//   rst_o   out  reset, asynchronous assert / synchronous release
// STAGES must be at least 2.
// -----------------------------------------------------------------------------
module rst_gen #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk_i,
    input  logic arst_i,
    output logic rst_o
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    // Zeros shift in from the bottom; the top bit is the released reset.
    always_comb begin
        sync_d = {sync_q[STAGES-2:0], 1'b0};
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            sync_q <= '1;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign rst_o = sync_q[STAGES-1];

endmodule

// File: rtl/blink_seq.sv
// -----------------------------------------------------------------------------
// blink_seq
// Programmable status-LED sequencer. A pattern, step duration and repeat
// count are loaded over a valid/ready handshake while idle; the pattern is
// then played bit-serially (bit 0 first) on led_o, each bit lasting
// step*DIV clock cycles, for the requested number of passes (0 = forever).
// Ports:
//   clk_i          in   system clock
//   arst_i         in   asynchronous active-high reset (also drives rst_gen)
//   cfg_valid_i    in   configuration request
//   cfg_ready_o    out  high while idle and out of reset
//   cfg_pattern_i  in   LED level per step
//   cfg_len_i      in   steps per pass (0 or >PAT_W means PAT_W)
//   cfg_step_i     in   ticks per step (0 means 1)
//   cfg_repeat_i   in   passes to play (0 means until stop_i)
//   stop_i         in   abort playback
//   led_o          out  LED drive
//   busy_o         out  high while playing
//   done_o         out  one-cycle pulse after the final pass
// -----------------------------------------------------------------------------
module blink_seq
    import blink_pkg::*;
#(
    parameter int unsigned CLK_HZ  = DEF_CLK_HZ,
    parameter int unsigned TICK_HZ = DEF_TICK_HZ,
    parameter int unsigned PAT_W   = DEF_PAT_W,
    parameter int unsigned DUR_W   = DEF_DUR_W,
    parameter int unsigned REP_W   = DEF_REP_W
) (
    input  logic                  clk_i,
    input  logic                  arst_i,
    input  logic                  cfg_valid_i,
    output logic                  cfg_ready_o,
    input  logic [PAT_W-1:0]      cfg_pattern_i,
    input  logic [$clog2(PAT_W):0] cfg_len_i,
    input  logic [DUR_W-1:0]      cfg_step_i,
    input  logic [REP_W-1:0]      cfg_repeat_i,
    input  logic                  stop_i,
    output logic                  led_o,
    output logic                  busy_o,
    output logic                  done_o
);

    localparam int unsigned DIV   = calc_div(CLK_HZ, TICK_HZ);
    localparam int unsigned LEN_W = $clog2(PAT_W) + 1;
    localparam int unsigned IDX_W = cnt_w(PAT_W);

    logic rst_s;
    logic tick;
    logic hs;
    logic step_end;
    logic last_bit;

    state_e           state_q, state_d;
    logic [PAT_W-1:0] pat_q,   pat_d;
    logic [LEN_W-1:0] len_q,   len_d;
    logic [DUR_W-1:0] step_q,  step_d;
    // Remaining passes. Loaded with the repeat count; it stays 0 for the
    // endless mode because it is only decremented when non-zero.
    logic [REP_W-1:0] rem_q,   rem_d;
    logic [DUR_W-1:0] tcnt_q,  tcnt_d;
    logic [IDX_W-1:0] idx_q,   idx_d;
    logic             done_q,  done_d;

    rst_gen #(
        .STAGES (2)
    ) u_rst_gen (
        .clk_i  (clk_i),
        .arst_i (arst_i),
        .rst_o  (rst_s)
    );

    // The prescaler restarts on every accepted configuration and only runs
    // while playing, so the first step is exactly step*DIV cycles long.
    blink_tick #(
        .DIV (DIV)
    ) u_tick (
        .clk_i  (clk_i),
        .arst_i (arst_i),
        .srst_i (rst_s),
        .clr_i  (hs),
        .en_i   (state_q == ST_PLAY),
        .tick_o (tick)
    );

    assign hs       = cfg_valid_i && cfg_ready_o;
    assign step_end = (state_q == ST_PLAY) && tick && (tcnt_q == step_q - DUR_W'(1));
    assign last_bit = (idx_q == IDX_W'(len_q - LEN_W'(1)));

    // State register
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state_q <= ST_IDLE;
            pat_q   <= '0;
            len_q   <= '0;
            step_q  <= '0;
            rem_q   <= '0;
            tcnt_q  <= '0;
            idx_q   <= '0;
            done_q  <= 1'b0;
        end else if (rst_s) begin
            state_q <= ST_IDLE;
            pat_q   <= '0;
            len_q   <= '0;
            step_q  <= '0;
            rem_q   <= '0;
            tcnt_q  <= '0;
            idx_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            len_q   <= len_d;
            step_q  <= step_d;
            rem_q   <= rem_d;
            tcnt_q  <= tcnt_d;
            idx_q   <= idx_d;
            done_q  <= done_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        pat_d   = pat_q;
        len_d   = len_q;
        step_d  = step_q;
        rem_d   = rem_q;
        tcnt_d  = tcnt_q;
        idx_d   = idx_q;
        done_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // stop_i has no meaning here, so it cannot block a load.
                if (hs) begin
                    state_d = ST_PLAY;
                    pat_d   = cfg_pattern_i;
                    len_d   = LEN_W'(norm_len(32'(cfg_len_i), PAT_W));
                    step_d  = DUR_W'(norm_step(32'(cfg_step_i)));
                    rem_d   = cfg_repeat_i;
                    tcnt_d  = '0;
                    idx_d   = '0;
                end
            end

            ST_PLAY: begin
                // An abort takes priority over a coincident final pass end,
                // which is why it suppresses the done pulse.
                if (stop_i) begin
                    state_d = ST_IDLE;
                end else if (step_end) begin
                    tcnt_d = '0;
                    if (last_bit) begin
                        idx_d = '0;
                        if (rem_q != '0) begin
                            rem_d = rem_q - REP_W'(1);
                            if (rem_q == REP_W'(1)) begin
                                state_d = ST_IDLE;
                                done_d  = 1'b1;
                            end
                        end
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end else if (tick) begin
                    tcnt_d = tcnt_q + DUR_W'(1);
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output logic: everything is forced low while the reset is active so
    // the LED and handshake stay quiet until rst_gen releases.
    always_comb begin
        led_o       = 1'b0;
        busy_o      = 1'b0;
        cfg_ready_o = 1'b0;
        done_o      = done_q && !rst_s;
        if (!rst_s) begin
            case (state_q)
                ST_IDLE: cfg_ready_o = 1'b1;
                ST_PLAY: begin
                    busy_o = 1'b1;
                    led_o  = pat_q[idx_q];
                end
                default: begin
                    cfg_ready_o = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_blink_seq.sv
module tb_blink_seq;

    localparam int CLK_HZ  = 1000;
    localparam int TICK_HZ = 100;
    localparam int DIV     = CLK_HZ / TICK_HZ;
    localparam int PAT_W   = 8;

    logic        clk;
    logic        arst;
    logic        cfg_valid;
    logic        cfg_ready_o;
    logic [7:0]  cfg_pattern;
    logic [3:0]  cfg_len;
    logic [11:0] cfg_step;
    logic [7:0]  cfg_rep;
    logic        stop;
    logic        led_o;
    logic        busy_o;
    logic        done_o;

    int n_total = 0;
    int n_pass  = 0;
    int cyc     = 0;
    logic chk_en = 1'b0;

    blink_seq #(
        .CLK_HZ  (CLK_HZ),
        .TICK_HZ (TICK_HZ),
        .PAT_W   (PAT_W),
        .DUR_W   (12),
        .REP_W   (8)
    ) dut (
        .clk_i         (clk),
        .arst_i        (arst),
        .cfg_valid_i   (cfg_valid),
        .cfg_ready_o   (cfg_ready_o),
        .cfg_pattern_i (cfg_pattern),
        .cfg_len_i     (cfg_len),
        .cfg_step_i    (cfg_step),
        .cfg_repeat_i  (cfg_rep),
        .stop_i        (stop),
        .led_o         (led_o),
        .busy_o        (busy_o),
        .done_o        (done_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural model: playback is a timeline. m_t counts cycles since the
    // first played cycle; the LED is the pattern bit selected by how many
    // whole steps have elapsed, modulo the pass length.
    logic       m_play = 1'b0;
    logic       m_done = 1'b0;
    int         m_t    = 0;
    logic [7:0] m_pat  = 8'h00;
    int         m_len  = 1;
    int         m_step = 1;
    int         m_rep  = 0;
    int         rst_cnt = 2;
    logic       exp_rst;
    logic       exp_led, exp_busy, exp_done, exp_ready;

    assign exp_rst = arst || (rst_cnt != 0);

    always_comb begin
        exp_led   = 1'b0;
        exp_busy  = 1'b0;
        exp_done  = 1'b0;
        exp_ready = 1'b0;
        if (!exp_rst) begin
            exp_busy  = m_play;
            exp_done  = m_done;
            exp_ready = !m_play;
            if (m_play) exp_led = m_pat[(m_t / (m_step * DIV)) % m_len];
        end
    end

    always @(posedge clk) begin
        m_done <= 1'b0;
        if (exp_rst) begin
            m_play <= 1'b0;
        end else if (m_play) begin
            if (stop) begin
                m_play <= 1'b0;
            end else begin
                m_t <= m_t + 1;
                if (m_rep != 0 && m_t + 1 == m_len * m_step * DIV * m_rep) begin
                    m_play <= 1'b0;
                    m_done <= 1'b1;
                end
            end
        end else if (cfg_valid) begin
            m_play <= 1'b1;
            m_t    <= 0;
            m_pat  <= cfg_pattern;
            m_len  <= (cfg_len == 0 || int'(cfg_len) > PAT_W) ? PAT_W : int'(cfg_len);
            m_step <= (cfg_step == 0) ? 1 : int'(cfg_step);
            m_rep  <= int'(cfg_rep);
        end
        // Reset stays effective for two edges after arst drops.
        if (arst) rst_cnt <= 2;
        else if (rst_cnt > 0) rst_cnt <= rst_cnt - 1;
    end

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    always @(negedge clk) begin
        if (chk_en)
            check("outputs{led,busy,done,ready}",
                  int'({led_o, busy_o, done_o, cfg_ready_o}),
                  int'({exp_led, exp_busy, exp_done, exp_ready}));
    end

    task automatic start_cfg(input logic [7:0] p, input logic [3:0] l,
                             input logic [11:0] s, input logic [7:0] r);
        @(posedge clk);
        #1;
        cfg_pattern = p;
        cfg_len     = l;
        cfg_step    = s;
        cfg_rep     = r;
        cfg_valid   = 1'b1;
    endtask

    task automatic wait_hs(output int n);
        int k;
        k = 0;
        n = -1;
        do begin
            @(negedge clk);
            k++;
        end while (!(cfg_valid && cfg_ready_o) && k < 3000);
        if (cfg_valid && cfg_ready_o) n = cyc;
        else check("handshake_timeout", 0, 1);
        @(posedge clk);
        #1;
        cfg_valid = 1'b0;
    endtask

    task automatic at_cycle(input int c);
        do @(negedge clk); while (cyc < c);
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!exp_ready && k < 3000);
        if (!exp_ready) check("idle_timeout", 0, 1);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int n, n2, m, s, run;
        logic stop_it;
        arst        = 1'b1;
        cfg_valid   = 1'b0;
        cfg_pattern = 8'h00;
        cfg_len     = 4'd0;
        cfg_step    = 12'd0;
        cfg_rep     = 8'd0;
        stop        = 1'b0;

        // Reset state and release through the reset conditioner
        @(posedge clk);
        #1;
        chk_en = 1'b1;
        @(negedge clk);
        check("rst_ready", int'(cfg_ready_o), 0);
        check("rst_led",   int'(led_o), 0);
        check("rst_busy",  int'(busy_o), 0);
        repeat (2) @(posedge clk);
        #1;
        arst = 1'b0;
        @(negedge clk); check("rel_ready_0", int'(cfg_ready_o), 0);
        @(negedge clk); check("rel_ready_1", int'(cfg_ready_o), 0);
        @(negedge clk); check("rel_ready_2", int'(cfg_ready_o), 1);

        // Basic pattern: 1,0,1 for 20 cycles each
        start_cfg(8'b0000_0101, 4'd3, 12'd2, 8'd1);
        wait_hs(n);
        at_cycle(n + 1);  check("basic_led_n1", int'(led_o), 1);
                          check("basic_busy_n1", int'(busy_o), 1);
        at_cycle(n + 20); check("basic_led_n20", int'(led_o), 1);
        at_cycle(n + 21); check("basic_led_n21", int'(led_o), 0);
        at_cycle(n + 41); check("basic_led_n41", int'(led_o), 1);
        at_cycle(n + 60); check("basic_busy_n60", int'(busy_o), 1);
                          check("basic_done_n60", int'(done_o), 0);
        at_cycle(n + 61); check("basic_done_n61", int'(done_o), 1);
                          check("basic_busy_n61", int'(busy_o), 0);
        at_cycle(n + 62); check("basic_done_n62", int'(done_o), 0);

        // Repeat, with the next config held valid during playback
        start_cfg(8'b01, 4'd2, 12'd1, 8'd3);
        wait_hs(n);
        start_cfg(8'hAA, 4'd0, 12'd0, 8'd1);
        at_cycle(n + 11); check("rep_led_n11", int'(led_o), 0);
        at_cycle(n + 30); check("rep_led_n30", int'(led_o), 1);
                          check("hold_ready_n30", int'(cfg_ready_o), 0);
        wait_hs(n2);
        check("hold_accept_cycle", n2, n + 61);
        // Normalisation: 8 steps of 10 cycles, 0,1,0,1,...
        at_cycle(n2 + 1);  check("norm_led_n1", int'(led_o), 0);
        at_cycle(n2 + 11); check("norm_led_n11", int'(led_o), 1);
        at_cycle(n2 + 80); check("norm_busy_n80", int'(busy_o), 1);
        at_cycle(n2 + 81); check("norm_done_n81", int'(done_o), 1);

        // stop_i in IDLE together with valid: accepted
        @(posedge clk);
        #1;
        stop        = 1'b1;
        cfg_pattern = 8'b11;
        cfg_len     = 4'd2;
        cfg_step    = 12'd1;
        cfg_rep     = 8'd1;
        cfg_valid   = 1'b1;
        s = cyc;
        wait_hs(n);
        stop = 1'b0;
        check("idle_stop_accept_cycle", n, s);
        at_cycle(n + 1); check("idle_stop_busy", int'(busy_o), 1);
        wait_idle();

        // Infinite playback, then abort
        start_cfg(8'b1, 4'd1, 12'd3, 8'd0);
        wait_hs(n);
        at_cycle(n + 501); check("inf_led_n501", int'(led_o), 1);
        at_cycle(n + 523); check("inf_busy_n523", int'(busy_o), 1);
        @(posedge clk);
        #1;
        stop = 1'b1;
        m = cyc;
        @(posedge clk);
        #1;
        stop = 1'b0;
        at_cycle(m + 1);
        check("stop_led",  int'(led_o), 0);
        check("stop_busy", int'(busy_o), 0);
        check("stop_done", int'(done_o), 0);
        at_cycle(m + 2); check("stop_done_m2", int'(done_o), 0);

        // Asynchronous reset mid-step
        start_cfg(8'hFF, 4'd8, 12'd1, 8'd0);
        wait_hs(n);
        at_cycle(n + 25); check("prereset_led", int'(led_o), 1);
        #2;
        arst = 1'b1;
        #1;
        check("arst_led",   int'(led_o), 0);
        check("arst_busy",  int'(busy_o), 0);
        check("arst_ready", int'(cfg_ready_o), 0);
        repeat (3) @(posedge clk);
        #1;
        arst = 1'b0;
        @(negedge clk); check("arst_rel_ready_0", int'(cfg_ready_o), 0);
        @(negedge clk); check("arst_rel_ready_1", int'(cfg_ready_o), 0);
        @(negedge clk); check("arst_rel_ready_2", int'(cfg_ready_o), 1);
                        check("arst_rel_busy", int'(busy_o), 0);

        // Randomised configurations with occasional aborts
        for (int i = 0; i < 20; i++) begin
            wait_idle();
            repeat ($urandom_range(0, 3)) @(posedge clk);
            start_cfg(8'($urandom), 4'($urandom_range(0, 15)),
                      12'($urandom_range(0, 3)), 8'($urandom_range(0, 3)));
            stop_it = (cfg_rep == 0) || ($urandom_range(0, 3) == 0);
            wait_hs(n);
            run = $urandom_range(1, 400);
            for (int k = 0; k < run; k++) begin
                @(negedge clk);
                if (!m_play) break;
            end
            if (stop_it && m_play) begin
                @(posedge clk);
                #1;
                stop = 1'b1;
                @(posedge clk);
                #1;
                stop = 1'b0;
            end
        end
        wait_idle();
        repeat (5) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/blink_seq.md
Name: blink_seq

Overview:
Sequencer for the board status LED. It replaces the fixed 1 s toggle with a programmable on/off pattern: software or a top-level FSM loads a pattern, a step duration and a repeat count over a valid/ready handshake. The block then plays the pattern bit-serially on led_o. It sits between the control logic and the LED pin, and instantiates the existing rst_gen for its internal synchronous reset.

Parameters:
CLK_HZ, 25000000, input clock frequency in Hz
TICK_HZ, 1000, step time base in Hz; DIV = CLK_HZ/TICK_HZ, must divide exactly and be >= 2
PAT_W, 16, maximum pattern length in bits
DUR_W, 12, width of step duration field, in ticks
REP_W, 8, width of repeat count field

Ports:
clk_i  in  1  system clock
arst_i  in  1  reset, asynchronous, active-high; fed to rst_gen, whose output is rst_s
cfg_valid_i  in  1  config request
cfg_ready_o  out  1  config accepted when valid and ready in the same cycle
cfg_pattern_i  in  PAT_W  LED level per step; bit 0 is played first
cfg_len_i  in  $clog2(PAT_W)+1  steps per pass; 0 or >PAT_W is treated as PAT_W
cfg_step_i  in  DUR_W  ticks per step; 0 is treated as 1
cfg_repeat_i  in  REP_W  passes to play; 0 means loop until stop_i
stop_i  in  1  abort playback
led_o  out  1  LED drive
busy_o  out  1  high while playing
done_o  out  1  one-cycle pulse when the final pass completes

Behaviour:
- Reset (arst_i asserted, or rst_s high):
  - led_o=0, busy_o=0, done_o=0, cfg_ready_o=0.
  - FSM goes to IDLE; all counters are cleared.
- FSM states:
  - IDLE: cfg_ready_o=1, led_o=0.
  - PLAY: cfg_ready_o=0, busy_o=1.
- IDLE -> PLAY on handshake at cycle N:
  - Latch pattern, effective len, effective step and repeat.
  - Clear the prescaler, the step-tick counter and the bit index.
  - Cycle N+1: led_o=pattern[0], busy_o=1.
- Tick: the prescaler counts 0..DIV-1 and pulses on DIV-1. It is free-running only in PLAY, so every step lasts exactly step*DIV cycles.
- Step end (tick counter reaches step-1 on a tick):
  - Bit index increments.
  - led_o takes the next pattern bit on the following cycle.
- Pass end (bit index == len-1 at step end):
  - Bit index wraps to 0.
  - If repeat == 0: continue forever.
  - Otherwise decrement the remaining-pass counter. If it reaches 0: go to IDLE; led_o=0, busy_o=0 and done_o=1 for exactly one cycle, all on the cycle after the step end.
- stop_i in PLAY:
  - Next cycle: IDLE, led_o=0, busy_o=0, done_o stays 0.
  - stop_i wins over a coincident pass end, so no done pulse is produced.
- stop_i in IDLE: ignored; a same-cycle cfg handshake is still accepted.
- cfg_valid_i in PLAY: not accepted. The requester must hold valid; it is accepted in the first IDLE cycle.
- Width rules:
  - Counters saturate at nothing; they wrap only by explicit compare.
  - The remaining-pass counter is REP_W wide.
  - The tick counter is DUR_W wide.
  - The prescaler is $clog2(DIV) wide.
- Reset mid-play: immediate return to the reset values above; no done pulse.

Decomposition:
- Shared package blink_pkg holds:
  - FSM state encoding (IDLE, PLAY).
  - DIV computation and counter width localparams.
  - The len/step normalisation function (0 -> max, 0 -> 1).
- Sub-module blink_tick: a prescaler with clear and enable inputs and a one-cycle tick output, reusable by the existing blink block.
- rst_gen is instantiated unchanged.

Test Plan:
Bench parameters: CLK_HZ=1000, TICK_HZ=100 (DIV=10), PAT_W=8.
- Basic pattern: cfg pattern=8'b0000_0101, len=3, step=2, repeat=1 -> led_o = 1, 0, 1, each for 20 cycles from cycle N+1. done_o pulses at N+61. busy_o is high N+1..N+60.
- Repeat: pattern=8'b01, len=2, step=1, repeat=3 -> 6 steps of 10 cycles alternating 1, 0. Exactly one done_o pulse, at N+61.
- Infinite and stop: repeat=0, pattern=8'b1, len=1 -> led_o stays 1 past 500 cycles. Assert stop_i at cycle M -> led_o=0 and busy_o=0 at M+1; no done_o.
- Normalisation: len=0, step=0, pattern=8'hAA, repeat=1 -> 8 steps of 10 cycles, led_o = 0, 1, 0, 1, ... Done at N+81.
- Handshake: cfg_valid_i held during PLAY -> cfg_ready_o stays 0 until the done cycle. Accepted in the first IDLE cycle. stop_i in IDLE together with valid -> config accepted.
- Reset: assert arst_i mid-step for 3 cycles -> outputs go to 0 asynchronously. cfg_ready_o returns only after rst_gen releases rst_s.
